seg7_digit_rx: RTL and testbench
================================

// Module: seg7_digit_rx
// PURPOSE
//  Receive side of the adder display bus: samples the 7-segment pattern lcd[6:0] plus overflow flag lcd_o.
//  Waits for the pattern to settle, then decodes it back to a BCD digit or an overflow/error token.
//  Each settled pattern is handed downstream exactly once over a valid/ready handshake.
//  Sits between the adder output and the self-check/scoreboard logic of the display path.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical synchronized samples required before decode (legal range 1..255)
//  ERR_CNT_W      8  width of the saturating error counter
// PORTS
//  clk        in   1          system clock; all state updates on rising edge
//  rst_n      in   1          synchronous reset, active-low
//  lcd        in   7          segment pattern {g,f,e,d,c,b,a}; asynchronous to clk
//  lcd_o      in   1          overflow flag accompanying lcd; asynchronous to clk
//  dig_valid  out  1          decoded token available
//  dig_ready  in   1          downstream accepts token when dig_valid & dig_ready
//  dig_value  out  4          BCD 0..9; 4'hF = overflow token; 4'hE = error token
//  dig_ovf    out  1          token is overflow (lcd=0000000, lcd_o=1)
//  dig_err    out  1          token is an unrecognised pattern
//  err_count  out  ERR_CNT_W  count of error tokens accepted; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): dig_valid=0, dig_value=0, dig_ovf=0, dig_err=0, err_count=0.
//   Reset also clears the synchronizer, the stability counter, cand and have_last=0, and sets state=SETTLE.
//  Input path: {lcd_o,lcd} passes through a 2-flop synchronizer; sample s (8 bits) = second-stage output.
//  Stability: cand holds the last s; cnt increments while s==cand and saturates at STABLE_CYCLES.
//   Any s!=cand loads cand=s and sets cnt=1.
//  Decode table {lcd_o,lcd} -> token; every other 8-bit combination gives value=E, err=1:
//   0:0_0111111  1:0_0000110  2:0_1011011  3:0_1001111  4:0_1100110
//   5:0_1101101  6:0_1111101  7:0_0000111  8:0_1111111  9:0_1100111
//   overflow: 1_0000000 -> value=F, ovf=1
//  FSM:
//   SETTLE : when cnt reaches STABLE_CYCLES, compare cand with last.
//            If have_last && cand==last -> WAIT_CHG (no re-emit).
//            Else register the decoded outputs, set last=cand and have_last=1, assert dig_valid -> PRESENT.
//   PRESENT: dig_value/dig_ovf/dig_err are held constant while dig_valid=1.
//            When dig_valid & dig_ready: dig_valid=0 on the next edge; err_count+=1 if dig_err (saturating).
//            Next state is SETTLE if cand!=last, else WAIT_CHG.
//   WAIT_CHG: when s!=last -> SETTLE (counter restarts from 1).
//  Latency: with lcd steady and dig_ready=1, dig_valid rises STABLE_CYCLES+2 clk edges after the change
//   (2 sync stages + STABLE_CYCLES samples). The token is consumed on the edge where valid&ready are both 1.
//  Boundary conditions:
//   - A glitch shorter than STABLE_CYCLES samples emits nothing. If the pattern returns to last, no token is emitted.
//   - Input changes during PRESENT do not alter the presented token. The stability counter keeps tracking,
//     so a new pattern already stable at handshake is emitted 1 cycle after the handshake (via SETTLE).
//   - Back-to-back: at most one token every 2 cycles (PRESENT -> SETTLE -> PRESENT).
//   - After reset, the first settled pattern is always emitted, including errors (have_last=0).
//   - Reset mid-handshake drops the presented token; err_count clears.
//   - err_count at all-ones stays all-ones on further error tokens.
// TESTING
//  1. rst_n=0 for 2 cycles, then lcd=0111111, lcd_o=0, ready=1 -> dig_valid at edge 6 after the change; value=0, ovf=0, err=0.
//  2. Sweep digits 0..9, each held 10 cycles; then 0000000/lcd_o=1 -> ten tokens 0..9, then value=F with ovf=1; no duplicates.
//  3. lcd=0000110 for 2 cycles, then back to the previous pattern (STABLE_CYCLES=4) -> no token emitted.
//  4. ready=0 while presenting 5, lcd switched to 7 -> value stays 5 until ready=1;
//     token 7 follows with dig_valid rising 1 cycle after the handshake.
//  5. lcd=1010101, lcd_o=0 -> value=E, err=1; after acceptance err_count=1.
//     ERR_CNT_W=2 with 5 distinct error patterns -> err_count=3.
//  6. rst_n=0 asserted while dig_valid=1 -> next edge dig_valid=0, err_count=0; the same pattern is re-emitted after reset.

Source files
------------

// File: rtl/seg7_digit_rx.sv
// Receive side of the adder display bus: synchronizes the 7-segment pattern plus overflow flag,
// waits for it to settle, decodes it to a BCD/overflow/error token and hands each new token downstream once.
module seg7_digit_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           lcd,
    input  logic                 lcd_o,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [3:0]           dig_value,
    output logic                 dig_ovf,
    output logic                 dig_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {SETTLE, PRESENT, WAIT_CHG} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t     state, state_nxt;
    logic [7:0] sync1, sync2;
    logic [7:0] cand, cand_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] last;
    logic       have_last;
    logic       emit, accept;
    logic [3:0] dec_value;
    logic       dec_ovf, dec_err;

    // The FSM looks at the post-update candidate/count so a pattern is emitted on
    // the same edge its STABLE_CYCLES-th identical sample is taken.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (sync2 != cand) begin
            cand_nxt = sync2;
            cnt_nxt  = 8'd1;
        end else if (cnt != STABLE) begin
            cnt_nxt = cnt + 8'd1;
        end
    end

    always_comb begin
        dec_value = 4'hE;
        dec_ovf   = 1'b0;
        dec_err   = 1'b0;
        case (cand_nxt)
            8'b0_0111111: dec_value = 4'd0;
            8'b0_0000110: dec_value = 4'd1;
            8'b0_1011011: dec_value = 4'd2;
            8'b0_1001111: dec_value = 4'd3;
            8'b0_1100110: dec_value = 4'd4;
            8'b0_1101101: dec_value = 4'd5;
            8'b0_1111101: dec_value = 4'd6;
            8'b0_0000111: dec_value = 4'd7;
            8'b0_1111111: dec_value = 4'd8;
            8'b0_1100111: dec_value = 4'd9;
            8'b1_0000000: begin
                dec_value = 4'hF;
                dec_ovf   = 1'b1;
            end
            default:      dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        accept    = 1'b0;
        case (state)
            SETTLE: begin
                if (cnt_nxt == STABLE) begin
                    if (have_last && cand_nxt == last) begin
                        state_nxt = WAIT_CHG;
                    end else begin
                        emit      = 1'b1;
                        state_nxt = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (dig_valid && dig_ready) begin
                    accept    = 1'b1;
                    state_nxt = (cand_nxt != last) ? SETTLE : WAIT_CHG;
                end
            end
            WAIT_CHG: begin
                if (sync2 != last) state_nxt = SETTLE;
            end
            default: state_nxt = SETTLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= SETTLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            cand      <= '0;
            cnt       <= '0;
            last      <= '0;
            have_last <= 1'b0;
            dig_valid <= 1'b0;
            dig_value <= '0;
            dig_ovf   <= 1'b0;
            dig_err   <= 1'b0;
            err_count <= '0;
        end else begin
            sync1 <= {lcd_o, lcd};
            sync2 <= sync1;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            if (emit) begin
                dig_valid <= 1'b1;
                dig_value <= dec_value;
                dig_ovf   <= dec_ovf;
                dig_err   <= dec_err;
                last      <= cand_nxt;
                have_last <= 1'b1;
            end
            if (accept) begin
                dig_valid <= 1'b0;
                if (dig_err && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_digit_rx.sv
// Directed bench for seg7_digit_rx: latency, digit sweep, glitch rejection, backpressure,
// error counting (including a saturating 2-bit counter) and reset during a presented token.
module tb_seg7_digit_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] lcd;
    logic       lcd_o;
    logic       dig_ready;
    logic       dig_valid, dig_ovf, dig_err;
    logic [3:0] dig_value;
    logic [7:0] err_count;
    logic       d2_valid, d2_ovf, d2_err;
    logic [3:0] d2_value;
    logic [1:0] d2_err_count;

    int errors = 0;
    int checks = 0;
    logic [5:0] tokens[$];

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111};
    logic [7:0] err_pats [5] = '{8'b0_1010101, 8'b0_0000001, 8'b0_1111110, 8'b1_1111111, 8'b0_0000000};

    always #5 clk = ~clk;

    seg7_digit_rx #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .lcd(lcd), .lcd_o(lcd_o),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_value(dig_value),
        .dig_ovf(dig_ovf), .dig_err(dig_err), .err_count(err_count)
    );

    seg7_digit_rx #(.STABLE_CYCLES(4), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .lcd(lcd), .lcd_o(lcd_o),
        .dig_valid(d2_valid), .dig_ready(dig_ready), .dig_value(d2_value),
        .dig_ovf(d2_ovf), .dig_err(d2_err), .err_count(d2_err_count)
    );

    // Log of accepted tokens {ovf, err, value}; sampled mid-cycle, handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && dig_valid && dig_ready) tokens.push_back({dig_ovf, dig_err, dig_value});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (dig_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " valid within budget"}, 32'(dig_valid), 32'd1);
    endtask

    // Holds reset for two edges and releases it with the given pattern already on the bus.
    task automatic reset_dut(input logic [7:0] pat);
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        {lcd_o, lcd} = pat;
    endtask

    initial begin
        rst_n = 1'b0;
        lcd = 7'b0;
        lcd_o = 1'b0;
        dig_ready = 1'b1;
        ticks(2);
        check("reset valid", 32'(dig_valid), 32'd0);
        check("reset value", 32'(dig_value), 32'd0);
        check("reset ovf", 32'(dig_ovf), 32'd0);
        check("reset err", 32'(dig_err), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);

        // 1: first token latency after reset
        rst_n = 1'b1;
        {lcd_o, lcd} = {1'b0, seg_tab[0]};
        ticks(5);
        check("t1 valid edge5", 32'(dig_valid), 32'd0);
        tick();
        check("t1 valid edge6", 32'(dig_valid), 32'd1);
        check("t1 value", 32'(dig_value), 32'd0);
        check("t1 ovf", 32'(dig_ovf), 32'd0);
        check("t1 err", 32'(dig_err), 32'd0);
        tick();
        check("t1 consumed", 32'(dig_valid), 32'd0);

        // 2: digit sweep then overflow, one token each
        reset_dut({1'b0, seg_tab[0]});
        tokens.delete();
        ticks(10);
        for (int d = 1; d < 10; d++) begin
            {lcd_o, lcd} = {1'b0, seg_tab[d]};
            ticks(10);
        end
        {lcd_o, lcd} = 8'b1_0000000;
        ticks(10);
        check("t2 token count", 32'(tokens.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            logic [5:0] got, exp;
            got = (i < tokens.size()) ? tokens[i] : 6'h3F;
            exp = (i < 10) ? {2'b00, 4'(i)} : 6'b10_1111;
            check($sformatf("t2 token %0d", i), 32'(got), 32'(exp));
        end

        // 3: short glitch returning to the last pattern emits nothing
        tokens.delete();
        {lcd_o, lcd} = {1'b0, 7'b0000110};
        ticks(2);
        {lcd_o, lcd} = 8'b1_0000000;
        ticks(12);
        check("t3 no token", 32'(tokens.size()), 32'd0);
        check("t3 valid low", 32'(dig_valid), 32'd0);

        // 4: backpressure holds token 5 while the bus moves to 7
        dig_ready = 1'b0;
        {lcd_o, lcd} = {1'b0, seg_tab[5]};
        wait_valid(20, "t4 five");
        check("t4 value 5", 32'(dig_value), 32'd5);
        {lcd_o, lcd} = {1'b0, seg_tab[7]};
        ticks(10);
        check("t4 held valid", 32'(dig_valid), 32'd1);
        check("t4 held value", 32'(dig_value), 32'd5);
        dig_ready = 1'b1;
        tick();
        check("t4 after handshake", 32'(dig_valid), 32'd0);
        tick();
        check("t4 next valid", 32'(dig_valid), 32'd1);
        check("t4 value 7", 32'(dig_value), 32'd7);
        tick();
        check("t4 token count", 32'(tokens.size()), 32'd2);

        // 5: error token and counting
        {lcd_o, lcd} = err_pats[0];
        wait_valid(20, "t5 err");
        check("t5 value E", 32'(dig_value), 32'hE);
        check("t5 err", 32'(dig_err), 32'd1);
        check("t5 ovf", 32'(dig_ovf), 32'd0);
        tick();
        check("t5 err_count 1", 32'(err_count), 32'd1);
        check("t5 narrow err_count 1", 32'(d2_err_count), 32'd1);

        reset_dut(err_pats[0]);
        ticks(10);
        for (int p = 1; p < 5; p++) begin
            {lcd_o, lcd} = err_pats[p];
            ticks(10);
        end
        check("t5 err_count 5", 32'(err_count), 32'd5);
        check("t5 narrow saturates", 32'(d2_err_count), 32'd3);

        // 6: reset while a token is presented
        dig_ready = 1'b0;
        {lcd_o, lcd} = {1'b0, seg_tab[3]};
        wait_valid(20, "t6 three");
        check("t6 value 3", 32'(dig_value), 32'd3);
        rst_n = 1'b0;
        tick();
        check("t6 reset valid", 32'(dig_valid), 32'd0);
        check("t6 reset err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        dig_ready = 1'b1;
        ticks(5);
        check("t6 not yet", 32'(dig_valid), 32'd0);
        tick();
        check("t6 re-emit valid", 32'(dig_valid), 32'd1);
        check("t6 re-emit value", 32'(dig_value), 32'd3);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
